// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_pkg
// Purpose : 1024x768@60 timing constants, frame-buffer address width,
//           colour defaults and the per-pixel timing-stage record.
// Rev     : 1.0  initial release
// ============================================================================
package vga_timing_pkg;

  localparam int H_ACTIVE = 1024;
  localparam int H_FP     = 24;
  localparam int H_SYNC   = 136;
  localparam int H_BP     = 160;
  localparam int V_ACTIVE = 768;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 6;
  localparam int V_BP     = 29;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int FB_ADDR_W = 20;

  localparam logic [23:0] FG_COLOR    = 24'hFFFFFF;
  localparam logic [23:0] BG_COLOR    = 24'h000000;
  localparam logic        SYNC_ACTIVE = 1'b0;

  // Timing decode for one pixel slot, carried down the latency pipeline
  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
    logic fs;
    logic vb;
  } vga_stage_t;

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_gen
// Purpose : Horizontal/vertical raster counters and stage-0 decode of
//           visible, hsync, vsync, frame-start and vblank.
// Rev     : 1.0  initial release
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP
) (
  input  logic       vga_clk,
  input  logic       rst,
  output vga_stage_t stage_o
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  // Next raster position: h wraps at end of line and advances v
  always_comb begin
    h_d = h_q + HW'(1);
    v_d = v_q;
    if (h_q == HW'(HT - 1)) begin
      h_d = '0;
      v_d = (v_q == VW'(VT - 1)) ? '0 : v_q + VW'(1);
    end
  end

  // Raster counters, restart at the top-left pixel on reset
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Stage-0 decode straight from the counters
  always_comb begin
    stage_o.vis = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
    stage_o.hs  = (32'(h_q) >= H_ACTIVE + H_FP) &&
                  (32'(h_q) <  H_ACTIVE + H_FP + H_SYNC);
    stage_o.vs  = (32'(v_q) >= V_ACTIVE + V_FP) &&
                  (32'(v_q) <  V_ACTIVE + V_FP + V_SYNC);
    stage_o.fs  = (h_q == '0) && (v_q == '0);
    stage_o.vb  = (32'(v_q) >= V_ACTIVE);
  end

endmodule
`default_nettype wire

// File: rtl/vga_1bpp_scanout.sv
`default_nettype none
// ============================================================================
// Module  : vga_1bpp_scanout
// Purpose : 1bpp frame-buffer scan-out: raster timing, linear read address,
//           latency-matched sync/blank pipeline and 1bpp-to-RGB expansion.
// Rev     : 1.0  initial release
// ============================================================================
module vga_1bpp_scanout
  import vga_timing_pkg::*;
#(
  parameter int          H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
  parameter int          H_FP        = vga_timing_pkg::H_FP,
  parameter int          H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int          H_BP        = vga_timing_pkg::H_BP,
  parameter int          V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
  parameter int          V_FP        = vga_timing_pkg::V_FP,
  parameter int          V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int          V_BP        = vga_timing_pkg::V_BP,
  parameter logic        SYNC_ACTIVE = vga_timing_pkg::SYNC_ACTIVE,
  parameter int          RD_LAT      = 1,
  parameter logic [23:0] FG_COLOR    = vga_timing_pkg::FG_COLOR,
  parameter logic [23:0] BG_COLOR    = vga_timing_pkg::BG_COLOR
) (
  input  logic                 vga_clk,
  input  logic                 rst,
  output logic [FB_ADDR_W-1:0] vga_addr,
  input  logic                 vga_dout,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [23:0]          rgb,
  output logic                 frame_start,
  output logic                 vblank
);

  localparam int NPIX = H_ACTIVE * V_ACTIVE;
  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(NPIX - 1);

  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
    $error("vga_1bpp_scanout: RD_LAT must be in 1..3");
  end
  if (NPIX > (1 << FB_ADDR_W)) begin : g_bad_size
    $error("vga_1bpp_scanout: visible area exceeds frame-buffer address space");
  end

  vga_stage_t stage0;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .vga_clk (vga_clk),
    .rst     (rst),
    .stage_o (stage0)
  );

  logic [FB_ADDR_W-1:0] addr_q, addr_d, addr_cur;

  // Linear raster address: frame start forces pixel 0, the counter wraps
  // after the last visible pixel so it never leaves the visible range
  always_comb begin
    addr_cur = stage0.fs ? '0 : addr_q;
    addr_d   = addr_cur;
    if (stage0.vis) begin
      addr_d = (addr_cur == LAST_ADDR) ? '0 : addr_cur + FB_ADDR_W'(1);
    end
  end

  assign vga_addr = stage0.vis ? addr_cur : '0;

  // Address counter register
  always_ff @(posedge vga_clk) begin
    if (rst) addr_q <= '0;
    else     addr_q <= addr_d;
  end

  vga_stage_t pipe_q [RD_LAT];
  vga_stage_t dly;

  // Delay the timing decode to line up with the returning pixel data
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= stage0;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dly = pipe_q[RD_LAT-1];

  // Output stage: colour expansion and sync polarity, registered together
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      de          <= 1'b0;
      rgb         <= '0;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else begin
      de          <= dly.vis;
      rgb         <= dly.vis ? (vga_dout ? FG_COLOR : BG_COLOR) : 24'h0;
      hsync       <= dly.hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync       <= dly.vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      frame_start <= dly.fs;
      vblank      <= dly.vb;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_1bpp_scanout.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_1bpp_scanout
// Purpose : Three scan-out instances (read latency 1, 2, 3) on a reduced
//           raster, each fed by its own frame-buffer model, compared every
//           cycle against a raster-arithmetic reference.
// Rev     : 1.0  initial release
// ============================================================================
module tb_vga_1bpp_scanout;

  localparam int HA = 16, HFP = 2, HS = 3, HBP = 4;
  localparam int VA = 8,  VFP = 1, VS = 2, VBP = 2;
  localparam int HT    = HA + HFP + HS + HBP;   // 25
  localparam int VT    = VA + VFP + VS + VBP;   // 13
  localparam int FRAME = HT * VT;               // 325
  localparam int NPIX  = HA * VA;               // 128
  localparam logic [23:0] FG = 24'h3CA5F1;
  localparam logic [23:0] BG = 24'h0A1200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [19:0] addr [3];
  logic        dout [3];
  logic        hs   [3];
  logic        vs   [3];
  logic        de   [3];
  logic        fsp  [3];
  logic        vb   [3];
  logic [23:0] rgb  [3];

  logic mem [NPIX];

  int k     = 0;   // clock edges since the last reset edge
  bit armed = 1'b0;
  int phase = 0;
  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [19:0] ap [3] = '{default: 20'd0};
    always @(posedge clk) begin
      ap[0] <= addr[g];
      ap[1] <= ap[0];
      ap[2] <= ap[1];
    end
    assign dout[g] = mem[ap[g][6:0]];

    vga_1bpp_scanout #(
      .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
      .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
      .SYNC_ACTIVE (1'b0), .RD_LAT (g + 1),
      .FG_COLOR (FG), .BG_COLOR (BG)
    ) u_dut (
      .vga_clk     (clk),
      .rst         (rst),
      .vga_addr    (addr[g]),
      .vga_dout    (dout[g]),
      .hsync       (hs[g]),
      .vsync       (vs[g]),
      .de          (de[g]),
      .rgb         (rgb[g]),
      .frame_start (fsp[g]),
      .vblank      (vb[g])
    );
  end

  always @(posedge clk) begin
    if (rst) begin
      k     <= 0;
      armed <= 1'b1;
    end else begin
      k <= k + 1;
    end
  end

  // Reference: address presented while the raster sits at position kk
  function automatic logic [19:0] exp_addr(input int kk);
    int p, h, v;
    p = kk % FRAME;
    h = p % HT;
    v = p / HT;
    if (h < HA && v < VA) return 20'(v * HA + h);
    return 20'd0;
  endfunction

  // Reference outputs {de, rgb, hsync, vsync, frame_start, vblank}:
  // they show the raster position lat+1 edges earlier, reset values before
  function automatic logic [28:0] exp_out(input int lat, input int kk);
    int p, h, v;
    logic vis, hsl, vsl;
    logic [23:0] col;
    if (kk < lat + 1) return {1'b0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0};
    p   = (kk - lat - 1) % FRAME;
    h   = p % HT;
    v   = p / HT;
    vis = (h < HA) && (v < VA);
    col = vis ? (mem[v * HA + h] ? FG : BG) : 24'h0;
    hsl = !((h >= HA + HFP) && (h < HA + HFP + HS));
    vsl = !((v >= VA + VFP) && (v < VA + VFP + VS));
    return {vis, col, hsl, vsl, (p == 0), (v >= VA)};
  endfunction

  task automatic check(input string nm, input int d,
                       input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      if (bad <= 25)
        $display("FAIL %s lat=%0d k=%0d got=%h want=%h", nm, d + 1, k, act, want);
    end
  endtask

  int de_hi = 0, hs_lo = 0, vs_lo = 0, vb_hi = 0, fs_n = 0, prev_fs = -1;

  // Single compare process, away from the active edge
  always @(negedge clk) begin
    logic [28:0] e;
    if (armed) begin
      for (int d = 0; d < 3; d++) begin
        e = exp_out(d + 1, k);
        check("addr",   d, 32'(addr[d]), 32'(exp_addr(k)));
        check("de",     d, 32'(de[d]),   32'(e[28]));
        check("rgb",    d, 32'(rgb[d]),  32'(e[27:4]));
        check("hsync",  d, 32'(hs[d]),   32'(e[3]));
        check("vsync",  d, 32'(vs[d]),   32'(e[2]));
        check("fstart", d, 32'(fsp[d]),  32'(e[1]));
        check("vblank", d, 32'(vb[d]),   32'(e[0]));
        if (k == 0) begin
          check("rst_de",    d, 32'(de[d]),   32'd0);
          check("rst_rgb",   d, 32'(rgb[d]),  32'd0);
          check("rst_hsync", d, 32'(hs[d]),   32'd1);
          check("rst_vsync", d, 32'(vs[d]),   32'd1);
          check("rst_fs",    d, 32'(fsp[d]),  32'd0);
          check("rst_vb",    d, 32'(vb[d]),   32'd0);
          check("rst_addr",  d, 32'(addr[d]), 32'd0);
        end
        if (k == d + 2) check("first_fs", d, 32'(fsp[d]), 32'd1);
      end
      if (phase == 1) begin
        if (k == HT)          check("line1_addr",  0, 32'(addr[0]), 32'd16);
        if (k == 7 * HT + 15) check("last_addr",   0, 32'(addr[0]), 32'd127);
        if (k == 8 * HT)      check("vblank_addr", 0, 32'(addr[0]), 32'd0);
        if (fsp[0]) begin
          if (prev_fs >= 0) check("fs_period", 0, 32'(k - prev_fs), 32'd325);
          prev_fs = k;
        end
        if (k >= 2 && k < 2 + FRAME) begin
          de_hi += int'(de[0]);
          hs_lo += int'(!hs[0]);
          vs_lo += int'(!vs[0]);
          vb_hi += int'(vb[0]);
          fs_n  += int'(fsp[0]);
        end
        if (k == 2 + FRAME) begin
          check("de_per_frame",    0, 32'(de_hi), 32'd128);
          check("hs_low_cycles",   0, 32'(hs_lo), 32'd39);
          check("vs_low_cycles",   0, 32'(vs_lo), 32'd50);
          check("vblank_cycles",   0, 32'(vb_hi), 32'd125);
          check("fs_per_frame",    0, 32'(fs_n),  32'd1);
        end
      end
    end
  end

  // Assert reset for len edges once the raster reaches position tgt
  task automatic reset_at(input int tgt, input int len);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(posedge clk);
      #1;
      if (k % FRAME == tgt) found = 1'b1;
    end
    if (!found) begin
      $display("FAIL reset_at target %0d never reached", tgt);
      $fatal(1, "raster position wait expired");
    end
    rst = 1'b1;
    repeat (len) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) mem[i] = 1'($urandom_range(0, 1));
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst   = 1'b0;
    phase = 1;
    repeat (3 * FRAME + 10) @(posedge clk);
    #1;
    phase = 2;
    // line 4, pixel 7: mid-frame, mid-line single-cycle reset
    reset_at(4 * HT + 7, 1);
    repeat (FRAME + 40) @(posedge clk);
    for (int r = 0; r < 6; r++) begin
      reset_at(int'($urandom_range(0, FRAME - 1)), int'($urandom_range(1, 3)));
      repeat ($urandom_range(20, 400)) @(posedge clk);
    end
    // land one reset inside the hsync window of a vblank line
    reset_at(9 * HT + HA + HFP + 1, 1);
    repeat (FRAME + 20) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
